// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the pipelined adder-subtractor:
//   add_flags_t  - packed carry/borrow, signed-overflow and zero flags
//   chunk_count  - chunk width for a W-bit operand split into STAGES chunks;
//                  returns 0 when W does not divide evenly, so callers can
//                  reject the parameter set at elaboration time
// ---------------------------------------------------------------------------
package arith_pkg;

  typedef struct packed {
    logic cout;
    logic v;
    logic z;
  } add_flags_t;

  function automatic int chunk_count(input int w, input int stages);
    if (stages <= 0 || (w % stages) != 0) return 0;
    return w / stages;
  endfunction

endpackage

// File: rtl/cla_chunk.sv
// ---------------------------------------------------------------------------
// cla_chunk
// Combinational CW-bit adder built from 4-bit carry-lookahead groups. Inside
// a group every carry is formed from the group carry-in plus the generate /
// propagate terms of the lower bits; group carries chain from group to group.
// A final partial group is used when CW is not a multiple of 4.
// Ports:
//   a, b   in  CW  addends
//   ci     in  1   carry into bit 0
//   s      out CW  sum
//   co     out 1   carry out of bit CW-1
//   c_msb  out 1   carry into bit CW-1 (needed for signed overflow)
// ---------------------------------------------------------------------------
module cla_chunk #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          ci,
  output logic [CW-1:0] s,
  output logic          co,
  output logic          c_msb
);

  localparam int NG = (CW + 3) / 4;

  logic [CW-1:0] w_gen;
  logic [CW-1:0] w_prop;
  logic [CW:0]   w_carry;

  assign w_gen  = a & b;
  assign w_prop = a ^ b;

  // Walk the groups: each bit's carry is the group's accumulated generate
  // OR (accumulated propagate AND group carry-in); the group's own G/P then
  // produce the carry handed to the next group.
  always_comb begin
    logic w_grpGen;
    logic w_grpProp;
    logic w_grpCin;
    w_carry   = '0;
    w_grpGen  = 1'b0;
    w_grpProp = 1'b1;
    w_grpCin  = ci;
    for (int gi = 0; gi < NG; gi++) begin
      w_grpGen  = 1'b0;
      w_grpProp = 1'b1;
      for (int j = 0; j < 4; j++) begin
        if (gi * 4 + j < CW) begin
          w_carry[gi*4+j] = w_grpGen | (w_grpProp & w_grpCin);
          w_grpGen        = w_gen[gi*4+j] | (w_prop[gi*4+j] & w_grpGen);
          w_grpProp       = w_grpProp & w_prop[gi*4+j];
        end
      end
      w_grpCin = w_grpGen | (w_grpProp & w_grpCin);
    end
    w_carry[CW] = w_grpCin;
  end

  assign s     = w_prop ^ w_carry[CW-1:0];
  assign co    = w_carry[CW];
  assign c_msb = w_carry[CW-1];

endmodule

// File: rtl/pipe_cla_add_sub.sv
// ---------------------------------------------------------------------------
// pipe_cla_add_sub
// Pipelined W-bit adder-subtractor. The operation is cut into STAGES chunks
// of CW = W/STAGES bits; stage k adds chunk k and registers the partial sum,
// the untouched upper operand chunks, the chunk carry and a running zero flag.
// Each stage has its own valid bit and a ready chain that lets empty stages
// always accept, so bubbles collapse.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake
//   sub, cin, x, y      operation (x-y when sub), carry/borrow in, operands
//   tag_in              sideband tag carried with the transaction
//   out_valid/out_ready output handshake
//   out, cout, v, z     result, carry/borrow out, signed overflow, zero
//   tag_out             tag of the presented result
// ---------------------------------------------------------------------------
module pipe_cla_add_sub
  import arith_pkg::*;
#(
  parameter int W      = 106,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic             cin,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out,
  output logic             cout,
  output logic             v,
  output logic             z,
  output logic [TAG_W-1:0] tag_out
);

  localparam int CW = W / STAGES;

  if (chunk_count(W, STAGES) == 0) begin : g_badWidth
    $error("pipe_cla_add_sub: W must be a multiple of STAGES");
  end

  // Index k of these arrays is the data entering stage k; index STAGES is
  // the last stage's register, i.e. the output.
  logic [W-1:0]     w_x    [STAGES+1];
  logic [W-1:0]     w_yn   [STAGES+1];
  logic [W-1:0]     w_sum  [STAGES+1];
  logic [TAG_W-1:0] w_tag  [STAGES+1];
  logic [STAGES:0]  w_valid;
  logic [STAGES:0]  w_carry;
  logic [STAGES:0]  w_zero;
  logic [STAGES:0]  w_sub;
  logic [STAGES:0]  w_cmsb;
  logic [STAGES:0]  w_adv;
  add_flags_t       w_flags;

  assign w_x[0]         = x;
  assign w_yn[0]        = y ^ {W{sub}};
  assign w_sum[0]       = '0;
  assign w_tag[0]       = tag_in;
  assign w_valid[0]     = in_valid;
  assign w_carry[0]     = cin ^ sub;
  assign w_zero[0]      = 1'b1;
  assign w_sub[0]       = sub;
  assign w_cmsb[0]      = 1'b0;
  assign w_adv[STAGES]  = out_ready;
  assign in_ready       = w_adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [W-1:0]     r_x;
    logic [W-1:0]     r_yn;
    logic [W-1:0]     r_sum;
    logic [TAG_W-1:0] r_tag;
    logic             r_valid;
    logic             r_carry;
    logic             r_zero;
    logic             r_sub;
    logic             r_cmsb;
    logic [CW-1:0]    w_s;
    logic             w_co;
    logic             w_chunkMsb;
    logic [W-1:0]     w_nextSum;

    cla_chunk #(.CW(CW)) u_chunk (
      .a     (w_x[k][CW*k +: CW]),
      .b     (w_yn[k][CW*k +: CW]),
      .ci    (w_carry[k]),
      .s     (w_s),
      .co    (w_co),
      .c_msb (w_chunkMsb)
    );

    // Partial result so far with this stage's chunk dropped into place.
    always_comb begin
      w_nextSum             = w_sum[k];
      w_nextSum[CW*k +: CW] = w_s;
    end

    // An empty stage can always take new data; a full one only when the
    // stage downstream is moving too.
    assign w_adv[k] = !r_valid || w_adv[k+1];

    // Stage register: loads whenever the stage advances, and only copies the
    // payload for a real transaction so held results never get disturbed.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_x     <= '0;
        r_yn    <= '0;
        r_sum   <= '0;
        r_tag   <= '0;
        r_carry <= 1'b0;
        r_zero  <= 1'b0;
        r_sub   <= 1'b0;
        r_cmsb  <= 1'b0;
      end else if (w_adv[k]) begin
        r_valid <= w_valid[k];
        if (w_valid[k]) begin
          r_x     <= w_x[k];
          r_yn    <= w_yn[k];
          r_sum   <= w_nextSum;
          r_tag   <= w_tag[k];
          r_carry <= w_co;
          r_zero  <= w_zero[k] & (w_s == '0);
          r_sub   <= w_sub[k];
          r_cmsb  <= w_chunkMsb;
        end
      end
    end

    assign w_x[k+1]     = r_x;
    assign w_yn[k+1]    = r_yn;
    assign w_sum[k+1]   = r_sum;
    assign w_tag[k+1]   = r_tag;
    assign w_valid[k+1] = r_valid;
    assign w_carry[k+1] = r_carry;
    assign w_zero[k+1]  = r_zero;
    assign w_sub[k+1]   = r_sub;
    assign w_cmsb[k+1]  = r_cmsb;
  end

  // Borrow is the inverted carry when subtracting; overflow compares the
  // carries into and out of the sign bit.
  assign w_flags.cout = w_carry[STAGES] ^ w_sub[STAGES];
  assign w_flags.v    = w_cmsb[STAGES] ^ w_carry[STAGES];
  assign w_flags.z    = w_zero[STAGES];

  assign out_valid = w_valid[STAGES];
  assign out       = w_sum[STAGES];
  assign tag_out   = w_tag[STAGES];
  assign cout      = w_flags.cout;
  assign v         = w_flags.v;
  assign z         = w_flags.z;

endmodule

// File: tb/tb_pipe_cla_add_sub.sv
// ---------------------------------------------------------------------------
// tb_pipe_cla_add_sub
// Three instances: A (W=8, STAGES=2) for directed vectors, backpressure and
// reset; B (W=106, STAGES=2) and C (W=64, STAGES=4) for random traffic with
// a mid-run reset. A scoreboard of plain-arithmetic expectations is compared
// against every presented result on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_pipe_cla_add_sub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] out;
    logic         cout;
    logic         v;
    logic         z;
    logic [3:0]   tag;
  } exp_t;

  exp_t expA[$];
  exp_t expB[$];
  exp_t expC[$];

  logic         aInValid = 1'b0, aInReady, aSub = 1'b0, aCin = 1'b0;
  logic         aOutValid, aOutReady = 1'b1, aCout, aV, aZ;
  logic [7:0]   aX = '0, aY = '0, aOut;
  logic [3:0]   aTagIn = '0, aTagOut;

  logic         bInValid = 1'b0, bInReady, bSub = 1'b0, bCin = 1'b0;
  logic         bOutValid, bOutReady = 1'b1, bCout, bV, bZ;
  logic [105:0] bX = '0, bY = '0, bOut;
  logic [3:0]   bTagIn = '0, bTagOut;

  logic         cInValid = 1'b0, cInReady, cSub = 1'b0, cCin = 1'b0;
  logic         cOutValid, cOutReady = 1'b1, cCout, cV, cZ;
  logic [63:0]  cX = '0, cY = '0, cOut;
  logic [3:0]   cTagIn = '0, cTagOut;

  pipe_cla_add_sub #(.W(8), .STAGES(2), .TAG_W(4)) u_dutA (
    .clk(clk), .rst(rst), .in_valid(aInValid), .in_ready(aInReady),
    .sub(aSub), .cin(aCin), .x(aX), .y(aY), .tag_in(aTagIn),
    .out_valid(aOutValid), .out_ready(aOutReady), .out(aOut),
    .cout(aCout), .v(aV), .z(aZ), .tag_out(aTagOut));

  pipe_cla_add_sub #(.W(106), .STAGES(2), .TAG_W(4)) u_dutB (
    .clk(clk), .rst(rst), .in_valid(bInValid), .in_ready(bInReady),
    .sub(bSub), .cin(bCin), .x(bX), .y(bY), .tag_in(bTagIn),
    .out_valid(bOutValid), .out_ready(bOutReady), .out(bOut),
    .cout(bCout), .v(bV), .z(bZ), .tag_out(bTagOut));

  pipe_cla_add_sub #(.W(64), .STAGES(4), .TAG_W(4)) u_dutC (
    .clk(clk), .rst(rst), .in_valid(cInValid), .in_ready(cInReady),
    .sub(cSub), .cin(cCin), .x(cX), .y(cY), .tag_in(cTagIn),
    .out_valid(cOutValid), .out_ready(cOutReady), .out(cOut),
    .cout(cCout), .v(cV), .z(cZ), .tag_out(cTagOut));

  // Reference arithmetic: a (w+1)-bit sum gives the carry, and signed
  // overflow is "operands agree in sign, result does not".
  function automatic exp_t model(input int w, input logic [127:0] ox,
                                 input logic [127:0] oy, input logic osub,
                                 input logic ocin, input logic [3:0] otag);
    exp_t         e;
    logic [127:0] mask;
    logic [127:0] yn;
    logic [128:0] full;
    mask   = (128'd1 << w) - 128'd1;
    yn     = (osub ? ~oy : oy) & mask;
    full   = {1'b0, ox & mask} + {1'b0, yn} + {128'd0, ocin ^ osub};
    e.out  = full[127:0] & mask;
    e.cout = full[w] ^ osub;
    e.v    = (ox[w-1] == yn[w-1]) && (e.out[w-1] != ox[w-1]);
    e.z    = (e.out == '0);
    e.tag  = otag;
    return e;
  endfunction

  function automatic void checkOutput(input string name, input logic [127:0] act,
                                      input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  // Scoreboard compare: every presented result must match the oldest
  // outstanding expectation; it is retired when the handshake completes.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      expA.delete();
      expB.delete();
      expC.delete();
    end else begin
      if (aOutValid) begin
        if (expA.size() == 0) checkOutput("A unexpected result", 1, 0);
        else begin
          e = expA[0];
          checkOutput("A out", aOut, e.out);
          checkOutput("A flags", {aCout, aV, aZ}, {e.cout, e.v, e.z});
          checkOutput("A tag", aTagOut, e.tag);
          if (aOutReady) void'(expA.pop_front());
        end
      end
      if (bOutValid) begin
        if (expB.size() == 0) checkOutput("B unexpected result", 1, 0);
        else begin
          e = expB[0];
          checkOutput("B out", bOut, e.out);
          checkOutput("B flags", {bCout, bV, bZ}, {e.cout, e.v, e.z});
          checkOutput("B tag", bTagOut, e.tag);
          if (bOutReady) void'(expB.pop_front());
        end
      end
      if (cOutValid) begin
        if (expC.size() == 0) checkOutput("C unexpected result", 1, 0);
        else begin
          e = expC[0];
          checkOutput("C out", cOut, e.out);
          checkOutput("C flags", {cCout, cV, cZ}, {e.cout, e.v, e.z});
          checkOutput("C tag", cTagOut, e.tag);
          if (cOutReady) void'(expC.pop_front());
        end
      end
      if (aInValid && aInReady) expA.push_back(model(8, aX, aY, aSub, aCin, aTagIn));
      if (bInValid && bInReady) expB.push_back(model(106, bX, bY, bSub, bCin, bTagIn));
      if (cInValid && cInReady) expC.push_back(model(64, cX, cY, cSub, cCin, cTagIn));
    end
  end

  // One transaction into A with out_ready high; returns two cycles later
  // with the result on the outputs.
  task automatic applyStimulus(input logic [7:0] ix, input logic [7:0] iy,
                               input logic isub, input logic icin,
                               input logic [3:0] itag);
    @(posedge clk); #1;
    aInValid = 1'b1; aX = ix; aY = iy; aSub = isub; aCin = icin; aTagIn = itag;
    checkOutput("A in_ready before transfer", aInReady, 1);
    @(posedge clk); #1;
    aInValid = 1'b0;
    checkOutput("A out_valid one cycle in", aOutValid, 0);
    @(posedge clk); #1;
    checkOutput("A out_valid at latency", aOutValid, 1);
  endtask

  task automatic checkVector(input logic [7:0] rOut, input logic rCout,
                             input logic rV, input logic rZ, input logic [3:0] rTag);
    checkOutput("A vector out", aOut, rOut);
    checkOutput("A vector cout", aCout, rCout);
    checkOutput("A vector v", aV, rV);
    checkOutput("A vector z", aZ, rZ);
    checkOutput("A vector tag", aTagOut, rTag);
  endtask

  task automatic randomizeBC();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    bX = r[105:0];
    r = {$urandom, $urandom, $urandom, $urandom};
    bY = r[105:0];
    cX = {$urandom, $urandom};
    cY = {$urandom, $urandom};
    bSub = 1'($urandom_range(0, 1)); bCin = 1'($urandom_range(0, 1));
    cSub = 1'($urandom_range(0, 1)); cCin = 1'($urandom_range(0, 1));
    bTagIn = 4'($urandom_range(0, 15)); cTagIn = 4'($urandom_range(0, 15));
    bInValid = 1'($urandom_range(0, 1)); cInValid = 1'($urandom_range(0, 1));
    bOutReady = ($urandom_range(0, 3) != 0); cOutReady = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    exp_t pin;
    int   accepted;
    int   nextTag;
    int   seenCount;
    int   firstCyc;
    int   lastCyc;
    int   latA, latB, latC;
    logic [3:0] seen [4];

    // Model pins: hand-computed results for the reference function itself.
    pin = model(8, 128'h7F, 128'h01, 1'b0, 1'b0, 4'd3);
    checkOutput("model 7F+01", {pin.out[7:0], pin.cout, pin.v, pin.z}, {8'h80, 3'b010});
    pin = model(8, 128'h80, 128'h01, 1'b1, 1'b0, 4'd0);
    checkOutput("model 80-01", {pin.out[7:0], pin.cout, pin.v, pin.z}, {8'h7F, 3'b010});
    pin = model(8, 128'h00, 128'h01, 1'b1, 1'b0, 4'd0);
    checkOutput("model 00-01", {pin.out[7:0], pin.cout, pin.v, pin.z}, {8'hFF, 3'b100});

    // Reset state while rst is held.
    #1;
    checkOutput("reset out_valid", aOutValid, 0);
    checkOutput("reset outputs", {aOut, aCout, aV, aZ, aTagOut}, 0);
    #11 rst = 1'b0;
    #1 checkOutput("in_ready after reset", aInReady, 1);

    // Directed arithmetic vectors.
    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0, 4'd3); checkVector(8'h80, 1'b0, 1'b1, 1'b0, 4'd3);
    applyStimulus(8'h00, 8'h01, 1'b1, 1'b0, 4'd5); checkVector(8'hFF, 1'b1, 1'b0, 1'b0, 4'd5);
    applyStimulus(8'h80, 8'h01, 1'b1, 1'b0, 4'd6); checkVector(8'h7F, 1'b0, 1'b1, 1'b0, 4'd6);
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 4'd7); checkVector(8'h00, 1'b1, 1'b0, 1'b1, 4'd7);
    applyStimulus(8'h05, 8'h04, 1'b1, 1'b1, 4'd8); checkVector(8'h00, 1'b0, 1'b0, 1'b1, 4'd8);

    // Backpressure: tags 1..4 with out_ready low; only two fit.
    @(posedge clk); #1;
    aOutReady = 1'b0; accepted = 0; nextTag = 1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      logic took;
      aInValid = 1'b1; aTagIn = 4'(nextTag); aX = 8'(nextTag * 17); aY = 8'h21;
      aSub = 1'b0; aCin = 1'b0;
      took = aInReady;
      @(posedge clk); #1;
      if (took) begin accepted++; nextTag++; end
    end
    checkOutput("accepted before stall", accepted, 2);
    checkOutput("in_ready when full", aInReady, 0);
    checkOutput("stalled tag_out", aTagOut, 1);
    aOutReady = 1'b1;
    #1 checkOutput("in_ready full with out_ready", aInReady, 1);
    seenCount = 0; firstCyc = -1; lastCyc = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (aOutValid && seenCount < 4) begin
        seen[seenCount] = aTagOut; seenCount++;
        if (firstCyc < 0) firstCyc = cyc;
        lastCyc = cyc;
      end
      if (aInValid && aInReady) nextTag++;
      @(posedge clk); #1;
      aTagIn = 4'(nextTag); aX = 8'(nextTag * 17);
      if (nextTag > 4) aInValid = 1'b0;
    end
    checkOutput("released result count", seenCount, 4);
    for (int i = 0; i < 4; i++) checkOutput("released tag order", seen[i], 4'(i + 1));
    checkOutput("released one per cycle", lastCyc - firstCyc, 3);

    // Random bubbles and stalls on A.
    for (int cyc = 0; cyc < 200; cyc++) begin
      aInValid = 1'($urandom_range(0, 1)); aOutReady = 1'($urandom_range(0, 1));
      aX = 8'($urandom); aY = 8'($urandom); aSub = 1'($urandom_range(0, 1));
      aCin = 1'($urandom_range(0, 1)); aTagIn = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    aInValid = 1'b0; aOutReady = 1'b1;
    for (int cyc = 0; cyc < 10 && expA.size() != 0; cyc++) begin @(posedge clk); #1; end
    checkOutput("A drained", expA.size(), 0);

    // Reset with two transactions in flight.
    aInValid = 1'b1; aX = 8'h11; aY = 8'h22; aSub = 1'b0; aCin = 1'b0; aTagIn = 4'd9;
    @(posedge clk); #1;
    aTagIn = 4'd10;
    @(posedge clk); #1;
    aInValid = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("mid reset out_valid", aOutValid, 0);
    checkOutput("mid reset outputs", {aOut, aCout, aV, aZ, aTagOut}, 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      checkOutput("no stale after reset", aOutValid, 0);
      @(posedge clk); #1;
    end
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b1, 4'd2); checkVector(8'h47, 1'b0, 1'b0, 1'b0, 4'd2);

    // Wide instances: random traffic with a reset in the middle.
    for (int cyc = 0; cyc < 300; cyc++) begin
      randomizeBC();
      if (cyc == 150) begin
        bInValid = 1'b0; cInValid = 1'b0;
        #1 rst = 1'b1;
        #1;
        checkOutput("B reset outputs", {bOutValid, bOut, bCout, bV, bZ, bTagOut}, 0);
        checkOutput("C reset outputs", {cOutValid, cOut, cCout, cV, cZ, cTagOut}, 0);
        @(posedge clk); #1 rst = 1'b0;
      end
      @(posedge clk); #1;
    end
    bInValid = 1'b0; cInValid = 1'b0; bOutReady = 1'b1; cOutReady = 1'b1;
    for (int cyc = 0; cyc < 12 && (expB.size() != 0 || expC.size() != 0); cyc++) begin
      @(posedge clk); #1;
    end
    checkOutput("B drained", expB.size(), 0);
    checkOutput("C drained", expC.size(), 0);

    // Latency of the wide instances from an empty pipeline.
    randomizeBC();
    bInValid = 1'b1; cInValid = 1'b1; bOutReady = 1'b1; cOutReady = 1'b1;
    @(posedge clk); #1;
    bInValid = 1'b0; cInValid = 1'b0;
    latA = 0; latB = 0; latC = 0;
    for (int n = 1; n <= 10; n++) begin
      if (bOutValid && latB == 0) latB = n;
      if (cOutValid && latC == 0) latC = n;
      @(posedge clk); #1;
    end
    checkOutput("B latency", latB, 2);
    checkOutput("C latency", latC, 4);
    checkOutput("B/C queues empty", expB.size() + expC.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
